ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch byte address after reset.
REQ-002 Parameter QDEPTH, default 2, instruction queue depth in entries (legal range 2..8).
REQ-003 sys_clk  input  1  clock; all state updates on the rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  instruction memory read request; always accepted by memory.
REQ-006 imem_addr  output  32  word-aligned byte address of the request; bits [1:0] always 2'b00.
REQ-007 imem_rdata  input  32  little-endian instruction word, valid exactly 1 cycle after imem_req.
REQ-008 redirect_valid  input  1  one-cycle pulse; restart fetch at redirect_pc.
REQ-009 redirect_pc  input  32  new fetch byte address.
REQ-010 instr_valid  output  1  queue head holds a valid instruction.
REQ-011 instr_ready  input  1  downstream decode accepts the head.
REQ-012 instr  output  32  queue-head instruction word.
REQ-013 instr_pc  output  32  byte address of instr.
REQ-014 fetch_misalign  output  1  one-cycle pulse; redirect_pc[1:0] was non-zero.

Function
REQ-015 Internal state: fetch PC register, 1-bit in-flight flag, 1-bit kill flag, QDEPTH-entry FIFO of {pc, instr}, occupancy count.
REQ-016 pop = instr_valid & instr_ready; a pop removes the FIFO head at the clock edge.
REQ-017 imem_req = !redirect_valid & ((count + inflight - pop) < QDEPTH); combinational path from instr_ready to imem_req is intended.
REQ-018 imem_addr = fetch PC; on imem_req, PC <= PC + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 32'h0) and inflight <= 1, else inflight <= 0.
REQ-019 Cycle after a request: if kill == 0, push {requested PC, imem_rdata} into FIFO; if kill == 1, discard the response.
REQ-020 instr_valid = (count != 0) & !redirect_valid; instr/instr_pc driven from FIFO head regardless of valid.
REQ-021 Fetch-to-valid latency: request in cycle N -> instr_valid at cycle N+2 (empty queue, no redirect).
REQ-022 Sustained throughput with instr_ready held high: one instruction per cycle, no bubbles.
REQ-023 Simultaneous push and pop: count unchanged; push and pop of a full queue are never both needed, since REQ-017 prevents overflow.
REQ-024 Full (count == QDEPTH, inflight == 0): imem_req = 0 until a pop.
REQ-025 Redirect cycle: imem_req = 0, instr_valid = 0, no pop; at the edge: FIFO flushed (count <= 0), PC <= {redirect_pc[31:2], 2'b00}, kill <= inflight.
REQ-026 kill clears one cycle after it is set, after its response is discarded.
REQ-027 First request after redirect is issued the cycle after redirect_valid, at the aligned redirect PC.
REQ-028 fetch_misalign registered: asserts the cycle after a redirect with redirect_pc[1:0] != 0, for one cycle.
REQ-029 Back-to-back redirects: the last one wins; each flushes the queue and the in-flight response again.
REQ-030 FIFO overflow or underflow is unreachable; the bench shall assert that it never occurs.

Reset
REQ-031 During reset: PC = RESET_PC, inflight = 0, kill = 0, count = 0, imem_req = 0, instr_valid = 0, fetch_misalign = 0.
REQ-032 First imem_req is in the first cycle after sys_rst_n deasserts.
REQ-033 Reset asserted mid-fetch drops all in-flight and queued instructions.
REQ-034 After reset, fetch resumes at RESET_PC.

Verification
REQ-035 Reset release, memory holds 0x00000093 at 0x0 and 0x00100113 at 0x4, instr_ready = 1 -> imem_addr 0x0 then 0x4; instr_valid from cycle 2 with instr_pc 0x0 then 0x4.
REQ-036 instr_ready = 0 for 10 cycles -> exactly QDEPTH (2) requests issued, count = 2, then imem_req = 0.
REQ-037 instr_ready = 1 continuously -> one instr per cycle.
REQ-038 Continuous-ready case -> instr_pc increments by 4 every cycle with no gaps.
REQ-039 redirect_valid with redirect_pc = 0x100 while a request is in flight -> stale response discarded; next instr_pc = 0x100 exactly 3 cycles after the redirect.
REQ-040 redirect_pc = 0x202 -> fetch_misalign pulses one cycle; fetch resumes at 0x200.
REQ-041 Redirect to 0xFFFFFFFC -> requests to 0xFFFFFFFC then 0x00000000.
REQ-042 sys_rst_n pulsed low mid-stream -> instr_valid = 0 immediately; next imem_addr = RESET_PC.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues sequential word fetches into a small queue and
// restarts at a new PC on redirect, discarding any stale in-flight response.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_misalign
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    logic          kill_q, kill_d;
    logic          misalign_q, misalign_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0]   fifo_pc_q    [QDEPTH];
    logic [31:0]   fifo_instr_q [QDEPTH];

    logic          pop;
    logic          push;
    logic [CW:0]   occ;

    assign instr_valid    = (count_q != '0) & ~redirect_valid;
    assign pop            = instr_valid & instr_ready;
    assign push           = inflight_q & ~kill_q & ~redirect_valid;
    assign occ            = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
    // Reset gates the request so nothing issues while sys_rst_n is low.
    assign imem_req       = sys_rst_n & ~redirect_valid & (occ < (CW + 1)'(QDEPTH));
    assign imem_addr      = {pc_q[31:2], 2'b00};
    assign instr          = fifo_instr_q[rd_ptr_q];
    assign instr_pc       = fifo_pc_q[rd_ptr_q];
    assign fetch_misalign = misalign_q;

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = imem_req;
        kill_d     = 1'b0;
        misalign_d = redirect_valid & (redirect_pc[1:0] != 2'b00);
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (imem_req) begin
            req_pc_d = imem_addr;
            pc_d     = imem_addr + 32'd4;
        end

        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            kill_d   = inflight_q;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PW'(QDEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(QDEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= req_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a memory model and a queue scoreboard that
// checks every pop, request decision and occupancy bound each cycle.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned QDEPTH   = 2;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_misalign;

    int checks;
    int failures;

    ifu_fetch #(
        .RESET_PC(RESET_PC),
        .QDEPTH  (QDEPTH)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .fetch_misalign(fetch_misalign)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0000_0093;
            32'h0000_0004: mem_word = 32'h0010_0113;
            default:       mem_word = ~a;
        endcase
    endfunction

    // Memory: read data valid exactly one cycle after the request.
    always @(posedge sys_clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        sb[$];
    logic        m_inflight;
    logic        m_kill;
    logic [31:0] m_pc;
    logic        m_pop;
    logic        m_val_exp;
    logic        m_req_exp;
    int          m_occ;

    always @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sb.delete();
            m_inflight = 1'b0;
            m_kill     = 1'b0;
            m_pc       = RESET_PC;
        end else begin
            m_pop     = instr_valid & instr_ready;
            m_val_exp = (sb.size() != 0) && !redirect_valid;
            checks++;
            if (instr_valid !== m_val_exp) begin
                failures++;
                $display("FAIL mon_valid t=%0t got=%b exp=%b", $time, instr_valid, m_val_exp);
            end
            m_occ     = sb.size() + int'(m_inflight) - int'(m_pop);
            m_req_exp = !redirect_valid && (m_occ < QDEPTH);
            checks++;
            if (imem_req !== m_req_exp) begin
                failures++;
                $display("FAIL mon_req t=%0t got=%b exp=%b", $time, imem_req, m_req_exp);
            end
            if (imem_req) begin
                checks++;
                if (imem_addr[1:0] !== 2'b00) begin
                    failures++;
                    $display("FAIL mon_align t=%0t got=%h exp=aligned", $time, imem_addr);
                end
            end
            if (m_pop) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL mon_underflow t=%0t got=pop exp=empty_queue_no_pop", $time);
                end else begin
                    if ({instr_pc, instr} !== {sb[0].pc, sb[0].ins}) begin
                        failures++;
                        $display("FAIL mon_head t=%0t got=%h/%h exp=%h/%h", $time,
                                 instr_pc, instr, sb[0].pc, sb[0].ins);
                    end
                    void'(sb.pop_front());
                end
            end
            if (redirect_valid) begin
                sb.delete();
                m_kill = m_inflight;
            end else begin
                if (m_inflight && !m_kill) begin
                    sb.push_back('{pc: m_pc, ins: mem_word(m_pc)});
                    checks++;
                    if (sb.size() > QDEPTH) begin
                        failures++;
                        $display("FAIL mon_overflow t=%0t got=%0d exp<=%0d", $time,
                                 sb.size(), QDEPTH);
                    end
                end
                m_kill = 1'b0;
            end
            m_inflight = imem_req;
            m_pc       = imem_addr;
        end
    end

    task automatic do_reset(input logic rdy);
        sys_rst_n      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = rdy;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
    endtask

    task automatic step;
        @(negedge sys_clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge sys_clk);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++; $display("FAIL rst_req got=%b exp=0", imem_req);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid);
        end
        checks++;
        if (fetch_misalign !== 1'b0) begin
            failures++; $display("FAIL rst_misalign got=%b exp=0", fetch_misalign);
        end
        @(negedge sys_clk);
        sys_rst_n   = 1'b1;
        instr_ready = 1'b1;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL rst_first_req got=%b/%h exp=1/00000000", imem_req, imem_addr);
        end
        step();
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h4, 1'b0}) begin
            failures++;
            $display("FAIL rst_second_req got=%b/%h/%b exp=1/00000004/0", imem_req, imem_addr,
                     instr_valid);
        end
        step();
        checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'h0000_0093}) begin
            failures++;
            $display("FAIL rst_instr0 got=%b/%h/%h exp=1/00000000/00000093", instr_valid,
                     instr_pc, instr);
        end
        step();
        checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h4, 32'h0010_0113}) begin
            failures++;
            $display("FAIL rst_instr1 got=%b/%h/%h exp=1/00000004/00100113", instr_valid,
                     instr_pc, instr);
        end
    endtask

    task automatic test_stall;
        int n;
        n = 0;
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            if (imem_req) n++;
            step();
        end
        checks++;
        if (n != QDEPTH) begin
            failures++; $display("FAIL stall_reqs got=%0d exp=%0d", n, QDEPTH);
        end
        checks++;
        if ({imem_req, instr_valid, instr_pc} !== {1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL stall_hold got=%b/%b/%h exp=0/1/00000000", imem_req, instr_valid,
                     instr_pc);
        end
        instr_ready = 1'b1;
        step();
        checks++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h4}) begin
            failures++; $display("FAIL stall_second got=%b/%h exp=1/00000004", instr_valid, instr_pc);
        end
    endtask

    task automatic test_stream;
        do_reset(1'b1);
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({instr_valid, instr_pc} !== {1'b1, 32'(4 * i)}) begin
                failures++;
                $display("FAIL stream_%0d got=%b/%h exp=1/%h", i, instr_valid, instr_pc, 32'(4 * i));
            end
            step();
        end
    endtask

    task automatic test_redirect;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        checks++;
        if ({imem_req, instr_valid} !== 2'b00) begin
            failures++; $display("FAIL redir_cycle got=%b/%b exp=0/0", imem_req, instr_valid);
        end
        @(negedge sys_clk);
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
            failures++;
            $display("FAIL redir_req got=%b/%h/%b exp=1/00000100/0", imem_req, imem_addr, instr_valid);
        end
        step();
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++; $display("FAIL redir_stale got=%b exp=0", instr_valid);
        end
        step();
        checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h100, ~32'h100}) begin
            failures++;
            $display("FAIL redir_first got=%b/%h/%h exp=1/00000100/%h", instr_valid, instr_pc,
                     instr, ~32'h100);
        end
    endtask

    task automatic test_misalign;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h202;
        #1;
        checks++;
        if (fetch_misalign !== 1'b0) begin
            failures++; $display("FAIL mis_early got=%b exp=0", fetch_misalign);
        end
        @(negedge sys_clk);
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({fetch_misalign, imem_addr} !== {1'b1, 32'h200}) begin
            failures++; $display("FAIL mis_pulse got=%b/%h exp=1/00000200", fetch_misalign, imem_addr);
        end
        step();
        checks++;
        if (fetch_misalign !== 1'b0) begin
            failures++; $display("FAIL mis_once got=%b exp=0", fetch_misalign);
        end
        step();
        checks++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h200}) begin
            failures++; $display("FAIL mis_resume got=%b/%h exp=1/00000200", instr_valid, instr_pc);
        end
    endtask

    task automatic test_wrap;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge sys_clk);
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            failures++; $display("FAIL wrap_top got=%b/%h exp=1/fffffffc", imem_req, imem_addr);
        end
        step();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL wrap_zero got=%b/%h exp=1/00000000", imem_req, imem_addr);
        end
        step();
        checks++;
        if (instr_pc !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_pc0 got=%h exp=fffffffc", instr_pc);
        end
        step();
        checks++;
        if (instr_pc !== 32'h0) begin
            failures++; $display("FAIL wrap_pc1 got=%h exp=00000000", instr_pc);
        end
    endtask

    task automatic test_back_to_back;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(negedge sys_clk);
        redirect_pc = 32'h401;
        #1;
        checks++;
        if ({imem_req, instr_valid, fetch_misalign} !== 3'b000) begin
            failures++;
            $display("FAIL b2b_second got=%b/%b/%b exp=0/0/0", imem_req, instr_valid, fetch_misalign);
        end
        @(negedge sys_clk);
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, fetch_misalign} !== {1'b1, 32'h400, 1'b1}) begin
            failures++;
            $display("FAIL b2b_req got=%b/%h/%b exp=1/00000400/1", imem_req, imem_addr, fetch_misalign);
        end
        step();
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_stale got=%b exp=0", instr_valid);
        end
        step();
        checks++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h400}) begin
            failures++; $display("FAIL b2b_first got=%b/%h exp=1/00000400", instr_valid, instr_pc);
        end
    endtask

    task automatic test_mid_reset;
        step();
        checks++;
        if (instr_valid !== 1'b1) begin
            failures++; $display("FAIL mrst_pre got=%b exp=1", instr_valid);
        end
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({instr_valid, imem_req} !== 2'b00) begin
            failures++; $display("FAIL mrst_drop got=%b/%b exp=0/0", instr_valid, imem_req);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, RESET_PC, 1'b0}) begin
            failures++;
            $display("FAIL mrst_resume got=%b/%h/%b exp=1/%h/0", imem_req, imem_addr, instr_valid,
                     RESET_PC);
        end
        step();
        step();
        checks++;
        if ({instr_valid, instr_pc} !== {1'b1, RESET_PC}) begin
            failures++; $display("FAIL mrst_first got=%b/%h exp=1/%h", instr_valid, instr_pc, RESET_PC);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        sys_rst_n      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        test_reset();
        test_stall();
        test_stream();
        test_redirect();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        repeat (4) @(negedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
